// File: rtl/pe_array_acc.sv
// pe_array_acc: KERNEL_SIZE signed MACs, registered adder tree, channel accumulator,
// bias add and saturation. Define RELU_EN to clamp negative results to zero.
module pe_array_acc #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 20,
    parameter int unsigned KERNEL_SIZE  = 9,
    parameter int unsigned BIAS_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned CH_CNT_WIDTH = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [CH_CNT_WIDTH-1:0]             cfg_num_ch,
    input  logic [BIAS_WIDTH-1:0]               bias_in,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [KERNEL_SIZE*INPUT_WIDTH-1:0]  ifm_in,
    input  logic [KERNEL_SIZE*INPUT_WIDTH-1:0]  wgt_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUTPUT_WIDTH-1:0]             out_data,
    output logic                                out_sat,
    output logic                                busy
);
    localparam int unsigned PW = 2 * INPUT_WIDTH;
    localparam int unsigned SW = PW + $clog2(KERNEL_SIZE);

    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    logic [CH_CNT_WIDTH-1:0] cnt_q, cnt_d, nch_q, nch_d;
    logic [BIAS_WIDTH-1:0]   bias_q, bias_d;

    logic                    v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
    logic [BIAS_WIDTH-1:0]   bias1_q, bias1_d;
    logic signed [PW-1:0]    prod_q [KERNEL_SIZE];
    logic signed [PW-1:0]    prod_d [KERNEL_SIZE];

    logic                    v2_q, v2_d, first2_q, first2_d, last2_q, last2_d;
    logic [BIAS_WIDTH-1:0]   bias2_q, bias2_d;
    logic signed [SW-1:0]    sum_q, sum_d;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0]     out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;

    logic                        adv, accept, is_first, is_last;
    logic [CH_CNT_WIDTH-1:0]     cur_nch;
    logic signed [SW-1:0]        tree;
    logic signed [ACC_WIDTH-1:0] acc_sum, result;

    always_comb begin
        adv      = !(out_valid_q && !out_ready);
        accept   = in_valid && adv;
        is_first = (cnt_q == '0);
        // A configured count of zero behaves as a single channel.
        if (is_first)
            cur_nch = (cfg_num_ch == '0) ? CH_CNT_WIDTH'(1) : cfg_num_ch;
        else
            cur_nch = nch_q;
        is_last = (cnt_q == cur_nch - CH_CNT_WIDTH'(1));

        cnt_d  = cnt_q;
        nch_d  = nch_q;
        bias_d = bias_q;
        if (accept) begin
            cnt_d = is_last ? '0 : cnt_q + CH_CNT_WIDTH'(1);
            if (is_first) begin
                nch_d  = cur_nch;
                bias_d = bias_in;
            end
        end

        for (int unsigned i = 0; i < KERNEL_SIZE; i++)
            prod_d[i] = $signed(ifm_in[i*INPUT_WIDTH +: INPUT_WIDTH]) *
                        $signed(wgt_in[i*INPUT_WIDTH +: INPUT_WIDTH]);

        tree = '0;
        for (int unsigned i = 0; i < KERNEL_SIZE; i++)
            tree = tree + {{(SW-PW){prod_q[i][PW-1]}}, prod_q[i]};

        acc_sum = (first2_q ? '0 : acc_q) + {{(ACC_WIDTH-SW){sum_q[SW-1]}}, sum_q};
        result  = acc_sum + {{(ACC_WIDTH-BIAS_WIDTH){bias2_q[BIAS_WIDTH-1]}}, bias2_q};

        v1_d = v1_q;  first1_d = first1_q;  last1_d = last1_q;  bias1_d = bias1_q;
        v2_d = v2_q;  first2_d = first2_q;  last2_d = last2_q;  bias2_d = bias2_q;
        sum_d       = sum_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (adv) begin
            v1_d     = accept;
            first1_d = accept && is_first;
            last1_d  = accept && is_last;
            // Bias travels with the beat so a back-to-back first beat cannot clobber it.
            bias1_d  = is_first ? bias_in : bias_q;

            v2_d     = v1_q;
            first2_d = first1_q;
            last2_d  = last1_q;
            bias2_d  = bias1_q;
            sum_d    = tree;

            out_valid_d = v2_q && last2_q;
            if (v2_q) begin
                if (last2_q) begin
                    acc_d     = '0;
                    out_sat_d = 1'b0;
                    if (result > OUT_MAX) begin
                        out_data_d = OUT_MAX[OUTPUT_WIDTH-1:0];
                        out_sat_d  = 1'b1;
                    end else if (result < OUT_MIN) begin
                        out_data_d = OUT_MIN[OUTPUT_WIDTH-1:0];
                        out_sat_d  = 1'b1;
                    end else begin
                        out_data_d = result[OUTPUT_WIDTH-1:0];
                    end
`ifdef RELU_EN
                    if (out_data_d[OUTPUT_WIDTH-1])
                        out_data_d = '0;
`else
`endif
                end else begin
                    acc_d = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            nch_q       <= '0;
            bias_q      <= '0;
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            bias1_q     <= '0;
            prod_q      <= '{default: '0};
            v2_q        <= 1'b0;
            first2_q    <= 1'b0;
            last2_q     <= 1'b0;
            bias2_q     <= '0;
            sum_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            nch_q       <= nch_d;
            bias_q      <= bias_d;
            v1_q        <= v1_d;
            first1_q    <= first1_d;
            last1_q     <= last1_d;
            bias1_q     <= bias1_d;
            if (adv)
                prod_q  <= prod_d;
            v2_q        <= v2_d;
            first2_q    <= first2_d;
            last2_q     <= last2_d;
            bias2_q     <= bias2_d;
            sum_q       <= sum_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = (cnt_q != '0) || v1_q || v2_q;

endmodule

// File: tb/tb_pe_array_acc.sv
// Directed bench for pe_array_acc: latency, accumulation, saturation, hold, reset abort.
module tb_pe_array_acc;
    localparam int IW = 8;
    localparam int OW = 20;
    localparam int K  = 9;
    localparam int BW = 16;
    localparam int CW = 7;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [CW-1:0]        cfg_num_ch;
    logic [BW-1:0]        bias_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [K*IW-1:0]      ifm_in;
    logic [K*IW-1:0]      wgt_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_sat;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;

    pe_array_acc #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .KERNEL_SIZE (K),
        .BIAS_WIDTH  (BW),
        .ACC_WIDTH   (32),
        .CH_CNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_num_ch(cfg_num_ch),
        .bias_in   (bias_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ifm_in    (ifm_in),
        .wgt_in    (wgt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int nch, input int bias, input int a, input int w);
        logic [IW-1:0] av, wv;
        av = IW'(a);
        wv = IW'(w);
        cfg_num_ch = CW'(nch);
        bias_in    = BW'(bias);
        for (int i = 0; i < K; i++) begin
            ifm_in[i*IW +: IW] = av;
            wgt_in[i*IW +: IW] = wv;
        end
        in_valid = 1'b1;
    endtask

    // Expect the result exactly two edges after the final beat's accept edge.
    task automatic expect_result(input string tag, input int data, input int sat);
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        tick();
        check({tag, "_lat2"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, data);
        check({tag, "_sat"}, out_sat, sat);
        tick();
        check({tag, "_drain"}, out_valid, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_num_ch = '0;
        bias_in    = '0;
        in_valid   = 1'b0;
        ifm_in     = '0;
        wgt_in     = '0;
        out_ready  = 1'b1;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Single channel
        set_beat(1, 5, 1, 2);
        tick();
        expect_result("single", 23, 0);

        // Three channels, busy while accumulating
        set_beat(3, -100, 10, 10);
        tick();
        check("b3_busy1", busy, 1);
        tick();
        check("b3_busy2", busy, 1);
        tick();
        expect_result("three_ch", 2600, 0);
        check("b3_idle", busy, 0);

        // Positive saturation
        set_beat(64, 0, 127, 127);
        for (int i = 0; i < 64; i++) tick();
        expect_result("sat_pos", 524287, 1);

        // Negative saturation
        set_beat(64, 0, -128, 127);
        for (int i = 0; i < 64; i++) tick();
        expect_result("sat_neg", -524288, 1);

        // num_ch = 0 treated as one channel
        set_beat(0, 0, 2, 3);
        tick();
        expect_result("nch_zero", 54, 0);

        // Back-to-back outputs with different biases
        set_beat(2, 7, 1, 1);
        tick();
        tick();
        set_beat(1, -6, 2, 2);
        tick();
        in_valid = 1'b0;
        tick();
        check("b2b_v1", out_valid, 1);
        check("b2b_d1", out_data, 25);
        tick();
        check("b2b_v2", out_valid, 1);
        check("b2b_d2", out_data, 30);
        tick();
        check("b2b_drain", out_valid, 0);

        // Output hold with pending beats
        out_ready = 1'b0;
        set_beat(1, -100, 10, 10);
        tick();
        set_beat(1, 5, 1, 2);
        tick();
        set_beat(1, 0, 1, 1);
        tick();
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, 800);
        check("hold_ready", in_ready, 0);
        set_beat(1, 0, 3, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_in_ready", in_ready, 0);
            check("hold_stable", out_data, 800);
            check("hold_valid_stable", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rel_v1", out_valid, 1);
        check("rel_d1", out_data, 23);
        tick();
        check("rel_v2", out_valid, 1);
        check("rel_d2", out_data, 9);
        tick();
        check("rel_drain", out_valid, 0);

        // Reset aborts a partial accumulation
        set_beat(3, 0, 10, 10);
        tick();
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_sat", out_sat, 0);
        check("arst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        set_beat(1, 5, 1, 2);
        tick();
        expect_result("post_rst", 23, 0);

        // Negative in-range result
        set_beat(1, -100, 0, 0);
        tick();
`ifdef RELU_EN
        expect_result("neg_bias", 0, 0);
`else
        expect_result("neg_bias", -100, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
